// File: rtl/axi_dmem_master.sv
// axi_dmem_master
//   Bridges the core's single-outstanding load/store port onto the AXI4-Lite
//   master channels of the data-memory slave. One request is accepted in IDLE,
//   issued as AR (load) or AW+W (store), and completed by a one-cycle
//   resp_valid pulse once R or B has been received.
// Ports
//   ACLK, ARESETn                   clock (rising edge), async active-low reset
//   req_valid/req_ready             core request handshake
//   req_we/addr/wdata/wstrb         request attributes (1 = store)
//   resp_valid/resp_rdata/resp_err  one-cycle response, load data, non-OKAY flag
//   AR*/R*/AW*/W*/B* _M             AXI4-Lite master channels
module axi_dmem_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   ARADDR_M,
    output logic                ARVALID_M,
    input  logic                ARREADY_M,
    input  logic [DATA_W-1:0]   RDATA_M,
    input  logic [1:0]          RRESP_M,
    input  logic                RVALID_M,
    output logic                RREADY_M,
    output logic [ADDR_W-1:0]   AWADDR_M,
    output logic                AWVALID_M,
    input  logic                AWREADY_M,
    output logic [DATA_W-1:0]   WDATA_M,
    output logic [DATA_W/8-1:0] WSTRB_M,
    output logic                WVALID_M,
    input  logic                WREADY_M,
    input  logic [1:0]          BRESP_M,
    input  logic                BVALID_M,
    output logic                BREADY_M
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  aw_done_q, w_done_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                WR_REQ: begin
                    // Each channel's VALID is gated by its own done flag, so it
                    // drops after its handshake and never comes back.
                    if (AWVALID_M && AWREADY_M) aw_done_q <= 1'b1;
                    if (WVALID_M && WREADY_M)   w_done_q  <= 1'b1;
                end
                RD_DATA: begin
                    if (RVALID_M) begin
                        rdata_q <= RDATA_M;
                        err_q   <= (RRESP_M != RESP_OKAY);
                    end
                end
                WR_RESP: begin
                    if (BVALID_M) err_q <= (BRESP_M != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        ARVALID_M  = 1'b0;
        RREADY_M   = 1'b0;
        AWVALID_M  = 1'b0;
        WVALID_M   = 1'b0;
        BREADY_M   = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_we ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                ARVALID_M = 1'b1;
                if (ARREADY_M) state_d = RD_DATA;
            end
            RD_DATA: begin
                RREADY_M = 1'b1;
                if (RVALID_M) state_d = RESP;
            end
            WR_REQ: begin
                AWVALID_M = !aw_done_q;
                WVALID_M  = !w_done_q;
                // A channel counts as done if it finished earlier or handshakes now.
                if ((aw_done_q || AWREADY_M) && (w_done_q || WREADY_M))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                BREADY_M = 1'b1;
                if (BVALID_M) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ARADDR_M   = addr_q;
    assign AWADDR_M   = addr_q;
    assign WDATA_M    = wdata_q;
    assign WSTRB_M    = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_axi_dmem_master.sv
module tb_axi_dmem_master;

    logic        ACLK, ARESETn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ARADDR_M, AWADDR_M, RDATA_M, WDATA_M;
    logic        ARVALID_M, ARREADY_M, RVALID_M, RREADY_M;
    logic        AWVALID_M, AWREADY_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
    logic [1:0]  RRESP_M, BRESP_M;
    logic [3:0]  WSTRB_M;

    int tests = 0;
    int fails = 0;

    axi_dmem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARADDR_M(ARADDR_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- slave model (drives on falling edge) ----------------
    logic [31:0] mem [bit [31:0]];
    int   ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic r_pend, b_pend, aw_got, w_got;
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [31:0] r_addr, ar_addr_s, aw_addr_s, w_data_s, wa, wd;
        logic [3:0]  w_strb_s, ws;
        ARREADY_M = 0; RVALID_M = 0; RDATA_M = '0; RRESP_M = '0;
        AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0; BRESP_M = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        r_addr = '0; ar_addr_s = '0; aw_addr_s = '0; w_data_s = '0; wa = '0; wd = '0;
        w_strb_s = '0; ws = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                ARREADY_M = 0; RVALID_M = 0; AWREADY_M = 0; WREADY_M = 0; BVALID_M = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            end else begin
                if (r_hs) r_pend = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; r_addr = ar_addr_s; end
                if (aw_hs) begin aw_got = 1; wa = aw_addr_s; end
                if (w_hs) begin w_got = 1; wd = w_data_s; ws = w_strb_s; end
                if (b_hs) b_pend = 0;
                if (aw_got && w_got) begin
                    logic [31:0] old;
                    old = rd(wa);
                    for (int i = 0; i < 4; i++)
                        if (ws[i]) old[i*8 +: 8] = wd[i*8 +: 8];
                    mem[wa] = old;
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                ARREADY_M = ARVALID_M && (ar_cnt >= ar_delay);
                RVALID_M  = r_pend && (r_cnt >= r_delay);
                RDATA_M   = rd(r_addr);
                RRESP_M   = rresp_cfg;
                AWREADY_M = AWVALID_M && (aw_cnt >= aw_delay);
                WREADY_M  = WVALID_M && (w_cnt >= w_delay);
                BVALID_M  = b_pend && (b_cnt >= b_delay);
                BRESP_M   = bresp_cfg;
                ar_hs = ARVALID_M && ARREADY_M; ar_addr_s = ARADDR_M;
                r_hs  = RVALID_M && RREADY_M;
                aw_hs = AWVALID_M && AWREADY_M; aw_addr_s = AWADDR_M;
                w_hs  = WVALID_M && WREADY_M; w_data_s = WDATA_M; w_strb_s = WSTRB_M;
                b_hs  = BVALID_M && BREADY_M;
                if (ar_hs) ar_cnt = 0; else if (ARVALID_M) ar_cnt++;
                if (!r_hs && r_pend) r_cnt++;
                if (aw_hs) aw_cnt = 0; else if (AWVALID_M) aw_cnt++;
                if (w_hs) w_cnt = 0; else if (WVALID_M) w_cnt++;
                if (!b_hs && b_pend) b_cnt++;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int ar_stab_err = 0, aw_stab_err = 0, w_stab_err = 0, overlap_err = 0;
    int dbl_resp_err = 0, acc_err = 0, resp_cnt = 0, b_hs_cnt = 0;

    initial begin
        logic p_ar, p_aw, p_w, p_resp;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        int outstanding;
        p_ar = 0; p_aw = 0; p_w = 0; p_resp = 0; outstanding = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge ACLK);
            #1;
            if (!ARESETn) begin
                p_ar = 0; p_aw = 0; p_w = 0; p_resp = 0; outstanding = 0;
            end else begin
                if (p_ar && (!ARVALID_M || ARADDR_M !== p_araddr)) ar_stab_err++;
                if (p_aw && (!AWVALID_M || AWADDR_M !== p_awaddr)) aw_stab_err++;
                if (p_w && (!WVALID_M || WDATA_M !== p_wdata || WSTRB_M !== p_wstrb)) w_stab_err++;
                p_ar = ARVALID_M && !ARREADY_M; p_araddr = ARADDR_M;
                p_aw = AWVALID_M && !AWREADY_M; p_awaddr = AWADDR_M;
                p_w  = WVALID_M && !WREADY_M; p_wdata = WDATA_M; p_wstrb = WSTRB_M;
                if ((ARVALID_M || RREADY_M) && (AWVALID_M || WVALID_M || BREADY_M)) overlap_err++;
                if (BVALID_M && BREADY_M) b_hs_cnt++;
                if (resp_valid) begin
                    resp_cnt++;
                    if (p_resp) dbl_resp_err++;
                    if (outstanding == 0) acc_err++; else outstanding--;
                end
                p_resp = resp_valid;
                if (req_valid && req_ready) begin
                    if (outstanding != 0) acc_err++;
                    outstanding++;
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output logic err, output int lat, output logic ok);
        int n;
        @(negedge ACLK);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 200) begin @(negedge ACLK); lat++; end
        ok = resp_valid;
        rdata = resp_rdata;
        err = resp_err;
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        int n;
        @(negedge ACLK);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        req_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [9:0] obs;
        ARESETn = 0;
        repeat (2) @(negedge ACLK);
        obs = {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, resp_valid, resp_err,
               (resp_rdata != 0), (ARADDR_M != 0), (WDATA_M != 0)};
        tests++;
        if (obs !== 10'b0) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
        end
        ARESETn = 1;
        @(negedge ACLK);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load_basic;
        start_req(1'b0, 32'h100, 32'h0, 4'h0);
        tests++;
        if (ARVALID_M !== 1'b1 || ARADDR_M !== 32'h100) begin
            fails++; $display("FAIL load_ar_c1: got v=%b a=%h want v=1 a=00000100", ARVALID_M, ARADDR_M);
        end
        @(negedge ACLK);
        tests++;
        if ({ARVALID_M, RREADY_M, resp_valid} !== 3'b010) begin
            fails++; $display("FAIL load_c2: got {arv,rrdy,rv}=%b want 010", {ARVALID_M, RREADY_M, resp_valid});
        end
        @(negedge ACLK);
        tests++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
            fails++; $display("FAIL load_resp_c3: got v=%b d=%h e=%b want v=1 d=deadbeef e=0",
                              resp_valid, resp_rdata, resp_err);
        end
        @(negedge ACLK);
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL load_c4: got rv=%b rdy=%b want rv=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_store_late_aw;
        logic [31:0] d; logic e, ok; int lat, b0;
        logic [3:0] obs [1:5];
        logic [3:0] exp_v [1:5];
        mem[32'h200] = 32'hCAFEF00D;
        aw_delay = 2;
        b0 = b_hs_cnt;
        // {AWVALID, WVALID, BREADY, resp_valid} for cycles 1..5 after accept
        exp_v[1] = 4'b1100; exp_v[2] = 4'b1000; exp_v[3] = 4'b1000;
        exp_v[4] = 4'b0010; exp_v[5] = 4'b0001;
        start_req(1'b1, 32'h200, 32'h12345678, 4'b0011);
        tests++;
        if (AWADDR_M !== 32'h200 || WDATA_M !== 32'h12345678 || WSTRB_M !== 4'b0011) begin
            fails++; $display("FAIL store_payload: got a=%h d=%h s=%b want 00000200 12345678 0011",
                              AWADDR_M, WDATA_M, WSTRB_M);
        end
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge ACLK);
            obs[c] = {AWVALID_M, WVALID_M, BREADY_M, resp_valid};
        end
        for (int c = 1; c <= 5; c++) begin
            tests++;
            if (obs[c] !== exp_v[c]) begin
                fails++; $display("FAIL store_cycle%0d: got {awv,wv,brdy,rv}=%b want %b", c, obs[c], exp_v[c]);
            end
        end
        tests++;
        if (resp_err !== 1'b0 || b_hs_cnt - b0 !== 1) begin
            fails++; $display("FAIL store_b: got err=%b bcount=%0d want err=0 bcount=1", resp_err, b_hs_cnt - b0);
        end
        aw_delay = 0;
        do_txn(1'b0, 32'h200, 32'h0, 4'h0, d, e, lat, ok);
        tests++;
        if (!ok || d !== 32'hCAFE5678 || e !== 1'b0) begin
            fails++; $display("FAIL store_readback: got ok=%b d=%h e=%b want ok=1 d=cafe5678 e=0", ok, d, e);
        end
    endtask

    task automatic test_load_stalls;
        int bad_ar, bad_rdy, nresp, resp_at;
        logic [31:0] d;
        mem[32'h400] = 32'h0BADF00D;
        ar_delay = 5; r_delay = 3;
        bad_ar = 0; bad_rdy = 0; nresp = 0; resp_at = 0; d = '0;
        start_req(1'b0, 32'h400, 32'h0, 4'h0);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge ACLK);
            if (c <= 6 && (ARVALID_M !== 1'b1 || ARADDR_M !== 32'h400)) bad_ar++;
            if (c >= 7 && ARVALID_M !== 1'b0) bad_ar++;
            if (c <= 11 && req_ready !== 1'b0) bad_rdy++;
            if (c == 12 && req_ready !== 1'b1) bad_rdy++;
            if (resp_valid) begin nresp++; resp_at = c; d = resp_rdata; end
        end
        ar_delay = 0; r_delay = 0;
        tests++;
        if (bad_ar != 0) begin
            fails++; $display("FAIL stall_ar_stable: got %0d bad cycles want 0", bad_ar);
        end
        tests++;
        if (bad_rdy != 0) begin
            fails++; $display("FAIL stall_req_ready: got %0d bad cycles want 0", bad_rdy);
        end
        tests++;
        if (nresp != 1 || resp_at != 11 || d !== 32'h0BADF00D) begin
            fails++; $display("FAIL stall_resp: got n=%0d at=%0d d=%h want n=1 at=11 d=0badf00d",
                              nresp, resp_at, d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e, ok; int lat;
        rresp_cfg = 2'b10;
        do_txn(1'b0, 32'h100, 32'h0, 4'h0, d, e, lat, ok);
        rresp_cfg = 2'b00;
        tests++;
        if (!ok || e !== 1'b1) begin
            fails++; $display("FAIL err_slverr_load: got ok=%b e=%b want ok=1 e=1", ok, e);
        end
        bresp_cfg = 2'b11;
        do_txn(1'b1, 32'h600, 32'h1, 4'hF, d, e, lat, ok);
        bresp_cfg = 2'b00;
        tests++;
        if (!ok || e !== 1'b1) begin
            fails++; $display("FAIL err_decerr_store: got ok=%b e=%b want ok=1 e=1", ok, e);
        end
        do_txn(1'b0, 32'h100, 32'h0, 4'h0, d, e, lat, ok);
        tests++;
        if (!ok || e !== 1'b0 || d !== 32'hDEADBEEF || lat != 3) begin
            fails++; $display("FAIL err_recover: got ok=%b e=%b d=%h lat=%0d want ok=1 e=0 d=deadbeef lat=3",
                              ok, e, d, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic        we_t [4];
        logic [31:0] ad_t [4];
        logic [31:0] wd_t [4];
        logic [3:0]  ws_t [4];
        logic [31:0] got_d [4];
        logic        got_e [4];
        int idx, rcnt, cyc, acc0, ov0, b0;
        logic acc, ok, e;
        logic [31:0] d;
        int lat;
        mem[32'h300] = 32'h11112222;
        mem[32'h304] = 32'h00000055;
        we_t[0] = 0; ad_t[0] = 32'h300; wd_t[0] = 32'h0;        ws_t[0] = 4'h0;
        we_t[1] = 1; ad_t[1] = 32'h300; wd_t[1] = 32'hA5A5A5A5; ws_t[1] = 4'hF;
        we_t[2] = 0; ad_t[2] = 32'h300; wd_t[2] = 32'h0;        ws_t[2] = 4'h0;
        we_t[3] = 1; ad_t[3] = 32'h304; wd_t[3] = 32'hFFFFFFFF; ws_t[3] = 4'h0;
        for (int i = 0; i < 4; i++) begin got_d[i] = '0; got_e[i] = 1'bx; end
        acc0 = acc_err; ov0 = overlap_err; b0 = b_hs_cnt;
        idx = 0; rcnt = 0; cyc = 0;
        @(negedge ACLK);
        req_valid = 1; req_we = we_t[0]; req_addr = ad_t[0]; req_wdata = wd_t[0]; req_wstrb = ws_t[0];
        while (rcnt < 4 && cyc < 300) begin
            acc = req_valid && req_ready;
            @(negedge ACLK);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    req_we = we_t[idx]; req_addr = ad_t[idx];
                    req_wdata = wd_t[idx]; req_wstrb = ws_t[idx];
                end else req_valid = 0;
            end
            if (resp_valid) begin got_d[rcnt] = resp_rdata; got_e[rcnt] = resp_err; rcnt++; end
        end
        req_valid = 0;
        tests++;
        if (rcnt != 4 || idx != 4) begin
            fails++; $display("FAIL b2b_count: got resp=%0d acc=%0d want 4 4", rcnt, idx);
        end
        tests++;
        if (got_d[0] !== 32'h11112222 || got_d[2] !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL b2b_load_data: got %h %h want 11112222 a5a5a5a5", got_d[0], got_d[2]);
        end
        tests++;
        if ({got_e[0], got_e[1], got_e[2], got_e[3]} !== 4'b0000) begin
            fails++; $display("FAIL b2b_err: got %b want 0000", {got_e[0], got_e[1], got_e[2], got_e[3]});
        end
        tests++;
        if (acc_err != acc0 || overlap_err != ov0 || b_hs_cnt - b0 != 2) begin
            fails++; $display("FAIL b2b_ordering: got accerr=%0d overlap=%0d b=%0d want 0 0 2",
                              acc_err - acc0, overlap_err - ov0, b_hs_cnt - b0);
        end
        do_txn(1'b0, 32'h304, 32'h0, 4'h0, d, e, lat, ok);
        tests++;
        if (!ok || d !== 32'h00000055) begin
            fails++; $display("FAIL b2b_zero_strobe: got ok=%b d=%h want ok=1 d=00000055", ok, d);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] d; logic e, ok; int lat;
        aw_delay = 50; w_delay = 50;
        start_req(1'b1, 32'h500, 32'h77777777, 4'hF);
        @(negedge ACLK);
        tests++;
        if ({AWVALID_M, WVALID_M} !== 2'b11) begin
            fails++; $display("FAIL rst_pre: got {awv,wv}=%b want 11", {AWVALID_M, WVALID_M});
        end
        #2 ARESETn = 0;
        #1;
        tests++;
        if ({AWVALID_M, WVALID_M, BREADY_M, req_ready} !== 4'b0001) begin
            fails++; $display("FAIL rst_async: got {awv,wv,brdy,rdy}=%b want 0001",
                              {AWVALID_M, WVALID_M, BREADY_M, req_ready});
        end
        aw_delay = 0; w_delay = 0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);
        tests++;
        if (req_ready !== 1'b1 || AWVALID_M !== 1'b0) begin
            fails++; $display("FAIL rst_release: got rdy=%b awv=%b want rdy=1 awv=0", req_ready, AWVALID_M);
        end
        do_txn(1'b0, 32'h100, 32'h0, 4'h0, d, e, lat, ok);
        tests++;
        if (!ok || d !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++; $display("FAIL rst_recover: got ok=%b d=%h e=%b want ok=1 d=deadbeef e=0", ok, d, e);
        end
    endtask

    task automatic test_protocol;
        tests++;
        if (ar_stab_err != 0 || aw_stab_err != 0 || w_stab_err != 0) begin
            fails++; $display("FAIL proto_stable: got ar=%0d aw=%0d w=%0d want 0 0 0",
                              ar_stab_err, aw_stab_err, w_stab_err);
        end
        tests++;
        if (overlap_err != 0 || dbl_resp_err != 0 || acc_err != 0) begin
            fails++; $display("FAIL proto_single: got overlap=%0d dblresp=%0d acc=%0d want 0 0 0",
                              overlap_err, dbl_resp_err, acc_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn = 0;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem[32'h100] = 32'hDEADBEEF;
        test_reset;
        test_load_basic;
        test_store_late_aw;
        test_load_stalls;
        test_errors;
        test_back_to_back;
        test_mid_reset;
        test_protocol;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
